// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: start/busy/done handshake bundle for the BCD-to-binary converter.
interface bcd_to_bin_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  ready;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic                  err;
    modport master (output start, bcd_in, input ready, busy, done, bin_out, err);
    modport slave  (input start, bcd_in, output ready, busy, done, bin_out, err);
endinterface

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential reverse double-dabble BCD-to-binary converter, one shift per clock.
// Define BCD_CHECK_EN to reject operands holding a digit above 9 with err instead of converting.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    bcd_to_bin_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t                 state_q, state_d;
    logic [BCD_W+BIN_W-1:0] work_q, work_d, iter;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0]       bin_out_q, bin_out_d;
    logic                   err_q, err_d;
    logic                   bad_digit;
    logic                   accept;
    assign accept = bus.start && (state_q != SHIFT);
    // One iteration: shift right, then pull every BCD digit that reached 8+ back down by 3.
    always_comb begin
        iter = work_q >> 1;
        for (int i = 0; i < DIGITS; i++)
            iter[BIN_W+4*i +: 4] = (iter[BIN_W+4*i +: 4] >= 4'd8) ? iter[BIN_W+4*i +: 4] - 4'd3
                                                                  : iter[BIN_W+4*i +: 4];
    end
`ifdef BCD_CHECK_EN
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            bad_digit = bad_digit | (bus.bcd_in[4*i +: 4] > 4'd9);
    end
`else
    assign bad_digit = 1'b0;
`endif
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        if (state_q == SHIFT) begin
            work_d = iter;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
                state_d   = DONE;
                bin_out_d = iter[BIN_W-1:0];
                err_d     = 1'b0;
            end
        end else if (accept && bad_digit) begin
            state_d   = DONE;
            work_d    = '0;
            cnt_d     = '0;
            bin_out_d = '0;
            err_d     = 1'b1;
        end else if (accept) begin
            state_d = SHIFT;
            work_d  = {bus.bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end
    assign bus.ready   = (state_q != SHIFT);
    assign bus.busy    = (state_q == SHIFT);
    assign bus.done    = (state_q == DONE);
    assign bus.bin_out = bin_out_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: randomized scoreboard bench for bcd_to_bin against a decimal-arithmetic model.
module tb_bcd_to_bin;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   busy_run = 0;
    logic [BIN_W-1:0] last_bin = '0;
    logic             last_err = 1'b0;
    logic [BIN_W:0]   exp_q[$];
    bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();
    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask
    // Reference: read the digits as a decimal number; invalid digits only matter with checking on.
    function automatic logic [BIN_W:0] model(input logic [4*DIGITS-1:0] v);
        int acc = 0;
        bit inv = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            int d = int'((v >> (4 * i)) & 4'hF);
            inv = inv | (d > 9);
            acc = acc * 10 + d;
        end
`ifdef BCD_CHECK_EN
        if (inv) return {1'b1, {BIN_W{1'b0}}};
`endif
        return {1'b0, acc[BIN_W-1:0]};
    endfunction
    function automatic logic [4*DIGITS-1:0] to_bcd(input int n);
        logic [4*DIGITS-1:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
            last_bin = '0;
            last_err = 1'b0;
        end else if (bus.done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got bin_out=%0d with no conversion pending at %0t", bus.bin_out, $time);
            end else begin
                logic [BIN_W:0] e;
                e = exp_q.pop_front();
                check("bin_out", int'(bus.bin_out), int'(e[BIN_W-1:0]));
                check("err", int'(bus.err), int'(e[BIN_W]));
                check("busy_cycles", busy_run, e[BIN_W] ? 0 : BIN_W);
            end
            last_bin = bus.bin_out;
            last_err = bus.err;
            busy_run = 0;
        end else begin
            check("hold_bin_out", int'(bus.bin_out), int'(last_bin));
            check("hold_err", int'(bus.err), int'(last_err));
            if (bus.busy) busy_run++;
        end
    end
    task automatic issue(input logic [4*DIGITS-1:0] v);
        int n = 0;
        while (!bus.ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) check("ready_timeout", 0, 1);
        bus.start  = 1'b1;
        bus.bcd_in = v;
        exp_q.push_back(model(v));
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = 12'($urandom);
    endtask
    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("done_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask
    task automatic check_reset_outputs();
        check("rst_ready", int'(bus.ready), 1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_bin_out", int'(bus.bin_out), 0);
        check("rst_err", int'(bus.err), 0);
    endtask
    initial begin
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(12'h999);
        wait_done();
        issue(12'h000);
        issue(12'h255);
        wait_done();
        // A start raised mid-conversion must be ignored: a second done would hit an empty queue.
        issue(12'h128);
        repeat (3) @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h900;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_done();
        issue(12'h500);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(12'h500);
        wait_done();
`ifdef BCD_CHECK_EN
        issue(12'h9A5);
        issue(12'h042);
        wait_done();
`endif
        for (int v = 0; v < 1000; v++) issue(to_bcd(v));
        wait_done();
        for (int k = 0; k < 200; k++) begin
            logic [4*DIGITS-1:0] r;
            for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(r);
        end
        wait_done();
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
